booth8_mac_pipe: RTL and testbench

Parametrised, pipelined radix-8 Booth multiply-accumulate block. Accepts signed operand pairs over a valid/ready handshake and accumulates ACC_LEN products per frame. At the end of each frame it emits one scaled, optionally rounded, saturated result over a valid/ready output. It is the frame-based MAC engine for the datapath.

---
 rtl/booth8_mac_pipe.sv | 167 ++++++++++++++++
 tb/tb_booth8_mac_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth8_mac_pipe.sv
// Pipelined radix-8 Booth multiply-accumulate: operand capture, Booth product,
// then frame accumulation with scaled, optionally rounded, saturated output.
module booth8_mac_pipe #(
  parameter int W       = 16,
  parameter int ACC_LEN = 256,
  parameter int SHIFT   = 13,
  parameter int OUT_W   = 27
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic                       round_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out,
  output logic [$clog2(ACC_LEN):0]   frame_cnt
);

  localparam int G     = (W + 2) / 3;
  localparam int AX_W  = 3 * G;
  localparam int PP_W  = W + 3;
  localparam int M3_W  = W + 2;
  localparam int P_W   = 2 * W;
  localparam int ACC_W = 2 * W + $clog2(ACC_LEN);
  localparam int CNT_W = $clog2(ACC_LEN) + 1;
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int RB    = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                     w_en;
  logic signed [M3_W-1:0]   w_b3;

  logic signed [W-1:0]      r_a;
  logic signed [W-1:0]      r_b;
  logic signed [M3_W-1:0]   r_b3;
  logic                     r_v1;

  logic signed [AX_W-1:0]   w_aext;
  logic        [AX_W:0]     w_ax;
  logic        [3:0]        w_dig;
  logic signed [PP_W-1:0]   w_m1, w_m2, w_m3, w_m4, w_pp;
  logic signed [P_W-1:0]    w_prod;

  logic signed [P_W-1:0]    r_prod;
  logic                     r_v2;

  logic signed [ACC_W-1:0]  w_total;
  logic signed [EXT_W-1:0]  w_sh, w_rnd;
  logic                     w_rbit;
  logic        [OUT_W-1:0]  w_sat;
  logic                     w_last;

  logic signed [ACC_W-1:0]  r_acc;
  logic        [CNT_W-1:0]  r_cnt;
  logic                     r_out_valid;
  logic        [OUT_W-1:0]  r_out;

  assign w_en      = !(r_out_valid && !out_ready);
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign frame_cnt = r_cnt;

  assign w_b3 = M3_W'($signed(b)) + (M3_W'($signed(b)) <<< 1);

  // S1: operand capture with hard multiple 3b
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_b3 <= '0;
      r_v1 <= 1'b0;
    end else if (clear) begin
      r_v1 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_a  <= $signed(a);
      r_b  <= $signed(b);
      r_b3 <= w_b3;
    end
  end

  // S2: radix-8 recode; sum is taken modulo 2^(2W), which is exact since a*b fits
  always_comb begin
    w_aext = AX_W'(r_a);
    w_ax   = {w_aext, 1'b0};
    w_m1   = PP_W'(r_b);
    w_m2   = w_m1 <<< 1;
    w_m3   = PP_W'(r_b3);
    w_m4   = w_m1 <<< 2;
    w_dig  = '0;
    w_pp   = '0;
    w_prod = '0;
    for (int unsigned i = 0; i < G; i++) begin
      w_dig = w_ax[3*i+3 -: 4];
      case (w_dig)
        4'b0001, 4'b0010: w_pp = w_m1;
        4'b0011, 4'b0100: w_pp = w_m2;
        4'b0101, 4'b0110: w_pp = w_m3;
        4'b0111:          w_pp = w_m4;
        4'b1000:          w_pp = -w_m4;
        4'b1001, 4'b1010: w_pp = -w_m3;
        4'b1011, 4'b1100: w_pp = -w_m2;
        4'b1101, 4'b1110: w_pp = -w_m1;
        default:          w_pp = '0;
      endcase
      w_prod = w_prod + (P_W'(w_pp) <<< (3*i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
      r_v2   <= 1'b0;
    end else if (clear) begin
      r_v2 <= 1'b0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_prod <= w_prod;
    end
  end

  // S3: frame result path; widened so OUT_W may exceed ACC_W
  always_comb begin
    w_total = r_acc + ACC_W'(r_prod);
    w_sh    = EXT_W'(w_total) >>> SHIFT;
    w_rbit  = (SHIFT > 0) && round_en && w_total[RB];
    w_rnd   = w_sh + $signed({{(EXT_W-1){1'b0}}, w_rbit});
    if (w_rnd > SAT_MAX)
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_rnd < SAT_MIN)
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
    else
      w_sat = w_rnd[OUT_W-1:0];
    w_last = r_v2 && (r_cnt == CNT_W'(ACC_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (clear) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_last;
      if (w_last) begin
        r_out <= w_sat;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_v2) begin
        r_acc <= w_total;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth8_mac_pipe.sv
// Directed bench for booth8_mac_pipe: four configurations share one stimulus bus,
// each scenario checks the instance it targets.
module tb_booth8_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, round_en, out_ready;
  logic [15:0] a, b;

  logic               x_in_ready, x_out_valid;
  logic signed [31:0] x_out;
  logic [0:0]         x_cnt;

  logic               d_in_ready, d_out_valid;
  logic signed [26:0] d_out;
  logic [8:0]         d_cnt;

  logic               s_in_ready, s_out_valid;
  logic signed [19:0] s_out;
  logic [8:0]         s_cnt;

  logic               b_in_ready, b_out_valid;
  logic signed [35:0] b_out;
  logic [2:0]         b_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth8_mac_pipe #(.W(16), .ACC_LEN(1), .SHIFT(0), .OUT_W(32)) u_x (
    .clk(clk), .rst(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(x_in_ready),
    .a(a), .b(b), .round_en(round_en), .out_valid(x_out_valid), .out_ready(out_ready),
    .out(x_out), .frame_cnt(x_cnt));

  booth8_mac_pipe #(.W(16), .ACC_LEN(256), .SHIFT(13), .OUT_W(27)) u_d (
    .clk(clk), .rst(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready),
    .a(a), .b(b), .round_en(round_en), .out_valid(d_out_valid), .out_ready(out_ready),
    .out(d_out), .frame_cnt(d_cnt));

  booth8_mac_pipe #(.W(16), .ACC_LEN(256), .SHIFT(13), .OUT_W(20)) u_s (
    .clk(clk), .rst(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .round_en(round_en), .out_valid(s_out_valid), .out_ready(out_ready),
    .out(s_out), .frame_cnt(s_cnt));

  booth8_mac_pipe #(.W(16), .ACC_LEN(4), .SHIFT(0), .OUT_W(36)) u_b (
    .clk(clk), .rst(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .a(a), .b(b), .round_en(round_en), .out_valid(b_out_valid), .out_ready(out_ready),
    .out(b_out), .frame_cnt(b_cnt));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // n consecutive pairs; returns at the negedge right after the last acceptance edge
  task automatic feed(input int n, input int aa, input int bb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(aa); b = 16'(bb);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (d_in_ready !== 1'b1) $display("FAIL rst_d_in_ready got %b want 1", d_in_ready); else n_pass++;
    n_total++; if (d_out_valid !== 1'b0) $display("FAIL rst_d_out_valid got %b want 0", d_out_valid); else n_pass++;
    n_total++; if (d_out !== 27'sd0) $display("FAIL rst_d_out got %0d want 0", d_out); else n_pass++;
    n_total++; if (d_cnt !== 9'd0) $display("FAIL rst_d_cnt got %0d want 0", d_cnt); else n_pass++;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL rst_b_in_ready got %b want 1", b_in_ready); else n_pass++;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL rst_b_out_valid got %b want 0", b_out_valid); else n_pass++;
    n_total++; if (b_out !== 36'sd0) $display("FAIL rst_b_out got %0d want 0", b_out); else n_pass++;
    n_total++; if (b_cnt !== 3'd0) $display("FAIL rst_b_cnt got %0d want 0", b_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_booth_exact();
    int ea[10] = '{-32768, -32768, 32767,  0, -1,     -1, 12345,  3,  32767, -7};
    int eb[10] = '{ 32767, -32768, 32767, -1, -1,  32767,  -678, -5, -32768,  1};
    int ep[10] = '{-1073709056, 1073741824, 1073676289, 0, 1, -32767, -8369910, -15, -1073709056, -7};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      feed(1, ea[i], eb[i]);
      @(negedge clk);
      n_total++; if (x_out_valid !== 1'b0) $display("FAIL exact_early_valid[%0d] got %b want 0", i, x_out_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (x_out_valid !== 1'b1) $display("FAIL exact_valid[%0d] got %b want 1", i, x_out_valid); else n_pass++;
      n_total++; if (x_out !== ep[i]) $display("FAIL exact_out[%0d] got %0d want %0d", i, x_out, ep[i]); else n_pass++;
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    out_ready = 1'b1; round_en = 1'b0;
    feed(256, -32768, -32768);
    n_total++; if (d_out_valid !== 1'b0) $display("FAIL full_valid_t0 got %b want 0", d_out_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (d_out_valid !== 1'b0) $display("FAIL full_valid_t1 got %b want 0", d_out_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (d_out_valid !== 1'b1) $display("FAIL full_valid_t2 got %b want 1", d_out_valid); else n_pass++;
    n_total++; if (d_out !== 27'sd33554432) $display("FAIL full_out got %0d want 33554432", d_out); else n_pass++;
    n_total++; if (d_cnt !== 9'd0) $display("FAIL full_cnt got %0d want 0", d_cnt); else n_pass++;
    n_total++; if (s_out !== 20'sd524287) $display("FAIL sat_pos_out got %0d want 524287", s_out); else n_pass++;
    @(negedge clk);
    n_total++; if (d_out_valid !== 1'b0) $display("FAIL full_valid_drop got %b want 0", d_out_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1; round_en = 1'b0;
    feed(256, -32768, 32767);
    @(negedge clk); @(negedge clk);
    n_total++; if (s_out_valid !== 1'b1) $display("FAIL sat_neg_valid got %b want 1", s_out_valid); else n_pass++;
    n_total++; if (s_out !== -20'sd524288) $display("FAIL sat_neg_out got %0d want -524288", s_out); else n_pass++;
    n_total++; if (d_out !== -27'sd33553408) $display("FAIL neg_unsat_out got %0d want -33553408", d_out); else n_pass++;
  endtask

  task automatic test_rounding();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      out_ready = 1'b1; round_en = (r == 1);
      feed(256, 1, 16);
      @(negedge clk); @(negedge clk);
      n_total++; if (d_out_valid !== 1'b1) $display("FAIL round_valid[%0d] got %b want 1", r, d_out_valid); else n_pass++;
      n_total++; if (d_out !== 27'(r)) $display("FAIL round_out[%0d] got %0d want %0d", r, d_out, r); else n_pass++;
    end
    round_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  acc_n = 0, res_n = 0, held = 0, post = 0, last_res = 0;
    logic released = 1'b0;
    do_reset();
    out_ready = 1'b0; round_en = 1'b0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      in_valid = (cyc < 36); a = 16'd1; b = 16'd1;
      if (!released && held >= 5) released = 1'b1;
      out_ready = released;
      #1;
      if (b_out_valid && !out_ready) begin
        held++;
        n_total++; if (b_in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d got %b want 0", cyc, b_in_ready); else n_pass++;
        n_total++; if (b_out !== 36'sd4) $display("FAIL bp_hold_out cyc%0d got %0d want 4", cyc, b_out); else n_pass++;
      end
      if (in_valid && b_in_ready) acc_n++;
      if (b_out_valid && out_ready) begin
        res_n++;
        n_total++; if (b_out !== 36'sd4) $display("FAIL b2b_out cyc%0d got %0d want 4", cyc, b_out); else n_pass++;
        if (post >= 2) begin
          n_total++; if (cyc - last_res != 4) $display("FAIL b2b_gap cyc%0d got %0d want 4", cyc, cyc - last_res); else n_pass++;
        end
        last_res = cyc; post++;
      end
    end
    n_total++; if (held != 5) $display("FAIL bp_held_cycles got %0d want 5", held); else n_pass++;
    n_total++; if (res_n != acc_n / 4) $display("FAIL b2b_count got %0d want %0d", res_n, acc_n / 4); else n_pass++;
    n_total++; if (b_cnt !== 3'(acc_n % 4)) $display("FAIL b2b_residue got %0d want %0d", b_cnt, acc_n % 4); else n_pass++;
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    feed(2, 1, 1);
    @(negedge clk); @(negedge clk);
    n_total++; if (b_cnt !== 3'd2) $display("FAIL clr_pre_cnt got %0d want 2", b_cnt); else n_pass++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_total++; if (b_cnt !== 3'd0) $display("FAIL clr_cnt got %0d want 0", b_cnt); else n_pass++;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL clr_valid got %b want 0", b_out_valid); else n_pass++;
    feed(4, 2, 3);
    @(negedge clk); @(negedge clk);
    n_total++; if (b_out_valid !== 1'b1) $display("FAIL clr_res_valid got %b want 1", b_out_valid); else n_pass++;
    n_total++; if (b_out !== 36'sd24) $display("FAIL clr_res_out got %0d want 24", b_out); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    out_ready = 1'b1;
    feed(2, 1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", b_out_valid); else n_pass++;
    n_total++; if (b_cnt !== 3'd0) $display("FAIL mrst_cnt got %0d want 0", b_cnt); else n_pass++;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL mrst_in_ready got %b want 1", b_in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (b_cnt !== 3'd0) $display("FAIL mrst_cnt_held got %0d want 0", b_cnt); else n_pass++;
    rst_n = 1'b1;
    feed(4, 2, 3);
    @(negedge clk); @(negedge clk);
    n_total++; if (b_out_valid !== 1'b1) $display("FAIL mrst_res_valid got %b want 1", b_out_valid); else n_pass++;
    n_total++; if (b_out !== 36'sd24) $display("FAIL mrst_res_out got %0d want 24", b_out); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; round_en = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    test_reset();
    test_booth_exact();
    test_full_scale();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
